// File: rtl/mem_access_pkg.sv
// mem_access_pkg: funct3 codes, stage state type and decode helpers for the load/store stage.
package mem_access_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      return store ? (f3 > F3_W) : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction
   // only meaningful for legal funct3: low two bits give the access size for loads and stores alike
   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
   endfunction
endpackage

// File: rtl/mem_access_lane_align.sv
// mem_lane_align: store byte-enable/data replication and load extract/extend from funct3 and addr[1:0].
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  f3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] sd_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o
);
   logic [7:0]  byte_s;
   logic [15:0] half_s;
   assign byte_s  = 8'(rdata_i >> {off_i, 3'b000});
   assign half_s  = 16'(rdata_i >> {off_i[1], 4'b0000});
   assign wstrb_o = f3_i[1:0] == 2'b00 ? 4'b0001 << off_i :
                    f3_i[1:0] == 2'b01 ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wdata_o = f3_i[1:0] == 2'b00 ? {4{sd_i[7:0]}} :
                    f3_i[1:0] == 2'b01 ? {2{sd_i[15:0]}} : sd_i;
   assign ldata_o = f3_i == F3_B  ? {{24{byte_s[7]}}, byte_s} :
                    f3_i == F3_BU ? {24'b0, byte_s} :
                    f3_i == F3_H  ? {{16{half_s[15]}}, half_s} :
                    f3_i == F3_HU ? {16'b0, half_s} : rdata_i;
endmodule

// File: rtl/mem_access.sv
// mem_access: RV32I load/store stage; one access per start pulse over a req/ready data-memory handshake.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enabled,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] alu_result,
   output logic        completed,
   output logic [31:0] rd_data,
   output logic        misaligned,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   mem_state_t  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        completed_q, completed_d, misaligned_q, misaligned_d, fault_q, fault_d, mem_we_q, mem_we_d;
   logic [31:0] rd_data_q, rd_data_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [3:0]  wstrb_s;
   logic [31:0] wdata_s, ldata_s;
   // decode the live inputs while idle, the latched ones once the access is in flight
   mem_lane_align u_align (
      .f3_i    (state_q == IDLE ? funct3 : f3_q),
      .off_i   (state_q == IDLE ? addr[1:0] : off_q),
      .sd_i    (store_data),
      .rdata_i (mem_rdata),
      .wstrb_o (wstrb_s),
      .wdata_o (wdata_s),
      .ldata_o (ldata_s)
   );
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         completed_q  <= 1'b0;
         misaligned_q <= 1'b0;
         fault_q      <= 1'b0;
         mem_we_q     <= 1'b0;
         rd_data_q    <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         f3_q         <= '0;
         off_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         completed_q  <= completed_d;
         misaligned_q <= misaligned_d;
         fault_q      <= fault_d;
         mem_we_q     <= mem_we_d;
         rd_data_q    <= rd_data_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
      end
   end
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      completed_d  = completed_q;
      misaligned_d = misaligned_q;
      fault_d      = fault_q;
      mem_we_d     = mem_we_q;
      rd_data_d    = rd_data_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      f3_d         = f3_q;
      off_d        = off_q;
      if (state_q == IDLE && enabled) begin
         f3_d  = funct3;
         off_d = addr[1:0];
         if (!is_load && !is_store) begin
            state_d     = DONE;
            completed_d = 1'b1;
            rd_data_d   = alu_result;
         end else if ((is_load && is_store) || f3_illegal(is_store, funct3)) begin
            state_d     = DONE;
            completed_d = 1'b1;
            fault_d     = 1'b1;
            rd_data_d   = '0;
         end else if (addr_misaligned(funct3, addr[1:0])) begin
            state_d      = DONE;
            completed_d  = 1'b1;
            misaligned_d = 1'b1;
            rd_data_d    = '0;
         end else begin
            state_d     = REQ;
            cnt_d       = '0;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = is_store ? wstrb_s : 4'b0000;
            mem_wdata_d = is_store ? wdata_s : 32'h0;
         end
      end else if (state_q == REQ) begin
         // ready beats the timeout when both land on the same cycle
         if (mem_ready) begin
            state_d     = DONE;
            completed_d = 1'b1;
            rd_data_d   = mem_we_q ? 32'h0 : ldata_s;
         end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
            state_d     = DONE;
            completed_d = 1'b1;
            fault_d     = 1'b1;
            rd_data_d   = '0;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end
   assign completed  = completed_q;
   assign rd_data    = rd_data_q;
   assign misaligned = misaligned_q;
   assign fault      = fault_q;
   assign mem_req    = state_q == REQ;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed load/store transactions checked every cycle against a transaction-level model.
module tb_mem_access;
   logic        clk, rstn, enabled, is_load, is_store, mem_ready;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data, alu_result, mem_rdata;
   logic        completed, misaligned, fault, mem_req, mem_we;
   logic [31:0] rd_data, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   bit          chk;
   logic        exp_comp, exp_req, exp_mis, exp_fault, exp_we;
   logic [31:0] exp_rd, exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;
   int          vecs, errs;
   typedef struct {
      bit          mem;
      logic [31:0] rd;
      bit          mis;
      bit          fault;
      logic [3:0]  strb;
      logic [31:0] wdata;
      int          size;
      bit          sgn;
   } res_t;
   mem_access #(.TIMEOUT(16)) dut (
      .clk(clk), .rstn(rstn), .enabled(enabled), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .alu_result(alu_result),
      .completed(completed), .rd_data(rd_data), .misaligned(misaligned), .fault(fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (chk) begin
         cmp("completed", 32'(completed), 32'(exp_comp));
         cmp("mem_req", 32'(mem_req), 32'(exp_req));
         cmp("rd_data", rd_data, exp_rd);
         cmp("fault", 32'(fault), 32'(exp_fault));
         cmp("misaligned", 32'(misaligned), 32'(exp_mis));
         if (exp_req) begin
            cmp("mem_addr", mem_addr, exp_addr);
            cmp("mem_we", 32'(mem_we), 32'(exp_we));
            cmp("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
            if (exp_we) cmp("mem_wdata", mem_wdata, exp_wdata);
         end
      end
   end
   // what the stage must produce for one instruction, straight from the access-size rules
   function automatic res_t predict(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] sd, input logic [31:0] alu);
      res_t r;
      int   sz;
      r = '{mem: 0, rd: 0, mis: 0, fault: 0, strb: 0, wdata: 0, size: 0, sgn: 0};
      if (!ld && !st) begin
         r.rd = alu;
         return r;
      end
      if (ld && st) begin
         r.fault = 1;
         return r;
      end
      case (f3)
         3'd0: sz = 1;
         3'd1: sz = 2;
         3'd2: sz = 4;
         3'd4: sz = ld ? 1 : 0;
         3'd5: sz = ld ? 2 : 0;
         default: sz = 0;
      endcase
      if (sz == 0) begin
         r.fault = 1;
         return r;
      end
      if (int'(a[1:0]) % sz != 0) begin
         r.mis = 1;
         return r;
      end
      r.mem  = 1;
      r.size = sz;
      r.sgn  = f3 < 3'd3;
      if (st) begin
         r.strb = 4'(((1 << sz) - 1) << int'(a[1:0]));
         for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
      end
      return r;
   endfunction
   function automatic logic [31:0] load_val(input logic [31:0] rdata, input logic [31:0] a, input int sz, input bit sgn);
      longint v;
      if (sz == 4) return rdata;
      v = (longint'(rdata) >> (8 * int'(a[1:0]))) & ((64'd1 << (8 * sz)) - 1);
      if (sgn && v >= longint'(64'd1 << (8 * sz - 1))) v -= longint'(64'd1 << (8 * sz));
      return 32'(v);
   endfunction
   task automatic clear_exp();
      exp_comp = 0; exp_req = 0; exp_mis = 0; exp_fault = 0; exp_we = 0;
      exp_rd = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
   endtask
   task automatic do_reset();
      rstn = 0; enabled = 0; mem_ready = 0;
      @(posedge clk); #1;
      rstn = 1;
      clear_exp();
      chk = 1;
      cmp("rst_mem_addr", mem_addr, 32'h0);
      cmp("rst_mem_wdata", mem_wdata, 32'h0);
      cmp("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      cmp("rst_mem_we", 32'(mem_we), 32'h0);
   endtask
   // rdy: index of the REQ cycle in which ready is raised (-1 = never)
   task automatic txn(input bit rst, input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input logic [31:0] alu, input logic [31:0] rdata, input int rdy,
                      input bit lit_on, input logic [3:0] lit_strb, input logic [31:0] lit_wd);
      res_t r;
      int   n;
      if (rst) do_reset();
      r = predict(ld, st, f3, a, sd, alu);
      is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd; alu_result = alu; enabled = 1;
      @(posedge clk); #1;
      enabled = 0; is_load = 0; is_store = 0; funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
      if (!r.mem) begin
         exp_comp = 1; exp_rd = r.rd; exp_fault = r.fault; exp_mis = r.mis;
      end else begin
         exp_req = 1; exp_we = st; exp_addr = {a[31:2], 2'b00};
         exp_wstrb = st ? r.strb : 4'b0; exp_wdata = r.wdata;
         if (lit_on) begin
            cmp("lit_wstrb", 32'(mem_wstrb), 32'(lit_strb));
            cmp("lit_wdata", mem_wdata, lit_wd);
         end
         n = 0;
         while (1) begin
            if (n == rdy) begin mem_ready = 1; mem_rdata = rdata; end
            enabled = n == 1;
            @(posedge clk); #1;
            mem_ready = 0; enabled = 0; mem_rdata = $urandom;
            n++;
            if (n - 1 == rdy) begin
               exp_req = 0; exp_comp = 1; exp_rd = st ? 32'h0 : load_val(rdata, a, r.size, r.sgn);
               break;
            end
            if (n == 16) begin
               exp_req = 0; exp_comp = 1; exp_fault = 1; exp_rd = 0;
               break;
            end
         end
      end
      @(posedge clk); #1;
      alu_result = 32'hFFFF_FFFF; enabled = 1;
      @(posedge clk); #1;
      enabled = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask
   initial begin
      chk = 0; vecs = 0; errs = 0; rstn = 0; enabled = 0; is_load = 0; is_store = 0; funct3 = 0;
      addr = 0; store_data = 0; alu_result = 0; mem_ready = 0; mem_rdata = 0;
      clear_exp();
      @(posedge clk); #1;
      txn(1, 0, 1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 0, 0, 1, 4'b1111, 32'hDEADBEEF);
      cmp("lit_sw_rd", rd_data, 32'h0);
      txn(1, 1, 0, 3'd0, 32'h203, 0, 0, 32'h80FF_0000, 0, 0, 0, 0);
      cmp("lit_lb", rd_data, 32'hFFFF_FF80);
      txn(1, 1, 0, 3'd4, 32'h203, 0, 0, 32'h80FF_0000, 0, 0, 0, 0);
      cmp("lit_lbu", rd_data, 32'h0000_0080);
      txn(1, 0, 1, 3'd0, 32'h12, 32'h0000_00A5, 0, 0, 1, 1, 4'b0100, 32'hA5A5_A5A5);
      txn(1, 1, 0, 3'd1, 32'h13, 0, 0, 0, 0, 0, 0, 0);
      cmp("lit_lh_mis", 32'(misaligned), 32'h1);
      txn(1, 0, 0, 3'd0, 32'h0, 0, 32'h0000_002A, 0, 0, 0, 0, 0);
      cmp("lit_add", rd_data, 32'h0000_002A);
      txn(1, 1, 0, 3'd2, 32'h300, 0, 0, 32'h1111_1111, -1, 0, 0, 0);
      cmp("lit_timeout_fault", 32'(fault), 32'h1);
      txn(1, 1, 0, 3'd2, 32'h304, 0, 0, 32'h1234_5678, 15, 0, 0, 0);
      cmp("lit_late_ready", rd_data, 32'h1234_5678);
      txn(1, 1, 0, 3'd1, 32'h202, 0, 0, 32'h8001_1234, 2, 0, 0, 0);
      cmp("lit_lh", rd_data, 32'hFFFF_8001);
      txn(1, 1, 0, 3'd5, 32'h200, 0, 0, 32'h0000_F00D, 3, 0, 0, 0);
      txn(1, 0, 1, 3'd1, 32'h06, 32'h1234_BEEF, 0, 0, 0, 1, 4'b1100, 32'hBEEF_BEEF);
      txn(1, 1, 0, 3'd3, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      txn(1, 0, 1, 3'd4, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      txn(1, 1, 1, 3'd2, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      txn(1, 0, 1, 3'd2, 32'h101, 32'h5, 0, 0, 0, 0, 0, 0);
      do_reset();
      is_load = 1; funct3 = 3'd2; addr = 32'h40; enabled = 1;
      @(posedge clk); #1;
      enabled = 0; is_load = 0;
      exp_req = 1; exp_we = 0; exp_addr = 32'h40; exp_wstrb = 0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 0;
      @(posedge clk); #1;
      rstn = 1;
      clear_exp();
      mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
      repeat (2) @(posedge clk);
      #1;
      mem_ready = 0;
      cmp("lit_rst_req", 32'(mem_req), 32'h0);
      cmp("lit_rst_comp", 32'(completed), 32'h0);
      txn(0, 1, 0, 3'd2, 32'h44, 0, 0, 32'h0BAD_CAFE, 0, 0, 0, 0);
      cmp("lit_after_rst", rd_data, 32'h0BAD_CAFE);
      chk = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
